idct_tpose_ctrl: RTL and testbench

Transpose-buffer controller between the row-pass and column-pass 1-D IDCT engines. It accepts the row-pass coefficient stream in row-major order and drives the write side of the ping-pong transpose RAM (`RAM`). It reads each completed block back in column-major order and presents it to the column pass over a valid/ready stream. Supported block sizes are 8x8 and 4x4.

---
 rtl/idct_pkg.sv | 34 +++
 rtl/idct_skid_fifo.sv | 55 +++++
 rtl/idct_tpose_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_idct_tpose_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// idct_pkg
//   Definitions shared by the IDCT transpose-buffer controller and its
//   output FIFO: writer/reader state encodings, block-size constants and
//   helpers for the last-element index and the column-major read address.
package idct_pkg;

  typedef enum logic {
    W_FILL = 1'b0,
    W_WAIT = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_e;

  localparam logic MODE_8X8 = 1'b1;
  localparam logic MODE_4X4 = 1'b0;

  localparam int BLK_8X8 = 64;
  localparam int BLK_4X4 = 16;

  // Index of the final element of a block for the given mode.
  function automatic logic [5:0] blk_last(input logic m);
    return (m == MODE_8X8) ? 6'(BLK_8X8 - 1) : 6'(BLK_4X4 - 1);
  endfunction

  // Column-major read address for read counter k: swapping the row and
  // column fields of k turns a row-major layout into column-major order.
  function automatic logic [5:0] tpose_addr(input logic m, input logic [5:0] k);
    return (m == MODE_8X8) ? {k[2:0], k[5:3]} : {2'b00, k[1:0], k[3:2]};
  endfunction

endpackage

// File: rtl/idct_skid_fifo.sv
// idct_skid_fifo
//   Two-entry FIFO between the RAM read-data capture and the column-pass
//   output stream. The producer has no ready: the controller only issues a
//   read when a slot is guaranteed, using the count output.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_data   : push one entry this cycle
//   out_valid, out_ready: output handshake (beat moves when both are high)
//   out_data            : head entry, stable while out_valid && !out_ready
//   count               : number of stored entries (0..2)
module idct_skid_fifo #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_pop;

  assign w_pop     = out_valid && out_ready;
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (in_valid) begin
        r_mem[r_wptr] <= in_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= r_count + {1'b0, in_valid} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/idct_tpose_ctrl.sv
// idct_tpose_ctrl
//   Transpose-buffer controller between the row-pass and column-pass 1-D
//   IDCT engines. Row-major input is written into one bank of a ping-pong
//   RAM while the other bank is read back column-major into a 2-entry FIFO.
//   Block size is 8x8 (mode[0]=1) or 4x4 (mode[0]=0).
//
// Optional feature: define IDCT_TPOSE_STATS_EN to add blk_cnt, a wrapping
// count of completed output blocks.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   mode                     : requested block size (bit 1 ignored)
//   in_valid/in_ready/in_data: row-pass input stream
//   ram_wr_rd                : RAM bank select (writer owns this bank)
//   ram_mode                 : {1'b0, latched block size}
//   ram_wr_addr/ram_data_in  : write port, rewritten by the RAM every clock
//   ram_rd_addr              : read address, sampled by the RAM every clock
//   ram_data_out             : read data, valid one edge after the address
//   out_valid/out_ready/out_data/out_last: column-pass output stream
//   blk_cnt                  : completed blocks (IDCT_TPOSE_STATS_EN only)
//   dbg_wr_state/dbg_rd_state: writer / reader FSM state
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high; valid never waits for ready, and while valid is high without ready
// the payload holds stable.
module idct_tpose_ctrl
  import idct_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              ram_wr_rd,
  output logic [1:0]        ram_mode,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
`ifdef IDCT_TPOSE_STATS_EN
  output logic [15:0]       blk_cnt,
`endif
  output logic              dbg_wr_state,
  output logic              dbg_rd_state
);

  wr_state_e         r_wr_state;
  rd_state_e         r_rd_state;
  logic [5:0]        r_wcnt;
  logic [5:0]        r_k;
  logic              r_mode_q;
  logic              r_wr_rd;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_inflight;
  logic              r_infl_last;

  logic [5:0]        w_last_idx;
  logic [1:0]        w_fifo_count;
  logic [DATA_W:0]   w_fifo_dout;
  logic [2:0]        w_occ;
  logic              w_empty;
  logic              w_accept;
  logic              w_swap;
  logic              w_issue;
  logic              w_pop;
  logic              w_unused;

  // mode[1] carries no meaning for this block.
  assign w_unused   = mode[1];

  assign w_last_idx = blk_last(r_mode_q);
  assign w_pop      = out_valid && out_ready;

  // Nothing buffered anywhere: the only point where the block size may move.
  assign w_empty = (r_wr_state == W_FILL) && (r_wcnt == 6'd0) &&
                   (r_rd_state == R_IDLE) && !r_inflight && (w_fifo_count == 2'd0);

  // A pending size change blocks input until the pipeline is empty; mode_q
  // then follows mode[0] and in_ready returns the cycle after.
  assign in_ready = !rst && (r_wr_state == W_FILL) && (mode[0] == r_mode_q);
  assign w_accept = in_valid && in_ready;

  assign w_swap   = (r_wr_state == W_WAIT) && (r_rd_state == R_IDLE);

  // Slots that will be occupied after this edge if no new read issues;
  // a read issues only when its data is sure to find a free FIFO slot.
  assign w_occ   = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_rd_state == R_DRAIN) && (w_occ < 3'd2);

  assign ram_wr_rd    = r_wr_rd;
  assign ram_mode     = {1'b0, r_mode_q};
  assign ram_wr_addr  = r_wr_addr;
  assign ram_data_in  = r_wr_data;
  // The RAM samples this address every edge; k rests at 0 when idle.
  assign ram_rd_addr  = ADDR_W'(tpose_addr(r_mode_q, r_k));
  assign dbg_wr_state = r_wr_state;
  assign dbg_rd_state = r_rd_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state  <= W_FILL;
      r_rd_state  <= R_IDLE;
      r_wcnt      <= '0;
      r_k         <= '0;
      r_mode_q    <= MODE_8X8;
      r_wr_rd     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      if (w_empty) begin
        r_mode_q <= mode[0];
      end

      if (w_accept) begin
        r_wr_addr <= ADDR_W'(r_wcnt);
        r_wr_data <= in_data;
        if (r_wcnt == w_last_idx) begin
          r_wcnt     <= '0;
          r_wr_state <= W_WAIT;
        end else begin
          r_wcnt <= r_wcnt + 6'd1;
        end
      end

      // Swap and issue are exclusive: swap needs the reader idle.
      if (w_swap) begin
        r_wr_rd    <= ~r_wr_rd;
        r_wr_state <= W_FILL;
        r_wcnt     <= '0;
        r_rd_state <= R_DRAIN;
        r_k        <= '0;
      end else if (w_issue) begin
        if (r_k == w_last_idx) begin
          r_rd_state <= R_IDLE;
          r_k        <= '0;
        end else begin
          r_k <= r_k + 6'd1;
        end
      end

      r_inflight  <= w_issue;
      r_infl_last <= w_issue && (r_k == w_last_idx);
    end
  end

  idct_skid_fifo #(
    .W(DATA_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (r_inflight),
    .in_data  ({r_infl_last, ram_data_out}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (w_fifo_dout),
    .count    (w_fifo_count)
  );

  assign out_last = w_fifo_dout[DATA_W];
  assign out_data = w_fifo_dout[DATA_W-1:0];

`ifdef IDCT_TPOSE_STATS_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_cnt <= 16'd0;
    end else if (w_pop && out_last) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`endif

endmodule

// File: tb/tb_idct_tpose_ctrl.sv
// tb_idct_tpose_ctrl
//   Bench for idct_tpose_ctrl with a behavioural ping-pong RAM. Expected
//   output beats are computed from the driven block and queued; the output
//   monitor pops and compares them. Build with IDCT_TPOSE_STATS_EN defined
//   to also cover blk_cnt.
module tb_idct_tpose_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  // ---------------- clock / reset / signals ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              ram_wr_rd;
  logic [1:0]        ram_mode;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_data_out;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              dbg_wr_state;
  logic              dbg_rd_state;
`ifdef IDCT_TPOSE_STATS_EN
  logic [15:0]       blk_cnt;
`endif

  always #5 clk = ~clk;

  idct_tpose_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ram_wr_rd   (ram_wr_rd),
    .ram_mode    (ram_mode),
    .ram_wr_addr (ram_wr_addr),
    .ram_data_in (ram_data_in),
    .ram_rd_addr (ram_rd_addr),
    .ram_data_out(ram_data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
`ifdef IDCT_TPOSE_STATS_EN
    .blk_cnt     (blk_cnt),
`endif
    .dbg_wr_state(dbg_wr_state),
    .dbg_rd_state(dbg_rd_state)
  );

  // Ping-pong RAM: writer bank is ram_wr_rd, reader bank the other one.
  logic [DATA_W-1:0] mem0 [64];
  logic [DATA_W-1:0] mem1 [64];

  always @(posedge clk) begin
    if (ram_wr_rd) mem1[ram_wr_addr] <= ram_data_in;
    else           mem0[ram_wr_addr] <= ram_data_in;
    ram_data_out <= ram_wr_rd ? mem0[ram_rd_addr] : mem1[ram_rd_addr];
  end

  // ---------------- scoreboard state ----------------
  logic [DATA_W:0] exp_q[$];
  int n_checks   = 0;
  int n_fail     = 0;
  int n_pop      = 0;
  int n_last_pop = 0;
  int n_toggle   = 0;
  int max_addr   = 0;
  bit bp_en      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output backpressure: toggles every cycle when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? ~out_ready : 1'b1;
    end
  end

  // Output monitor.
  logic [DATA_W:0] held_beat;
  logic [DATA_W:0] exp_beat;
  bit              hold_pend = 1'b0;
  bit              prev_wr_rd = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_beat", {15'd0, out_last, out_data}, {15'd0, held_beat});
      end
      hold_pend = out_valid && !out_ready;
      held_beat = {out_last, out_data};
      if (out_valid && out_ready) begin
        n_pop++;
        if (out_last) n_last_pop++;
        check("sb_not_empty", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check("out_beat", {15'd0, out_last, out_data}, {15'd0, exp_beat});
        end
      end
      if (ram_wr_rd != prev_wr_rd) n_toggle++;
      if (int'(ram_rd_addr) > max_addr) max_addr = int'(ram_rd_addr);
    end
    prev_wr_rd = ram_wr_rd;
  end

  // ---------------- driver tasks ----------------
  task automatic send_block(input int n, input bit rnd);
    logic [DATA_W-1:0] d [64];
    bit acc;
    int budget;
    for (int i = 0; i < n * n; i++)
      d[i] = rnd ? DATA_W'($urandom_range(0, 65535)) : DATA_W'(i);
    for (int c = 0; c < n; c++)
      for (int r = 0; r < n; r++)
        exp_q.push_back({(c == n - 1) && (r == n - 1), d[r * n + c]});
    for (int i = 0; i < n * n; i++) begin
      in_valid = 1'b1;
      in_data  = d[i];
      acc      = 1'b0;
      budget   = 0;
      while (!acc && budget < 3000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!acc) begin
        check("in_accept_timeout", {31'd0, acc}, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 0;
    while (exp_q.size() != 0 && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [1:0] mode;
    int         nblk;
    bit         bp;
    bit         rnd;
    bit         chk_lat;
    logic [1:0] exp_ram_mode;
    int         exp_outs;
    int         exp_max_addr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int pop0;
    int tog0;
    int budget;
    int lat;
    int n;

    vecs[0] = '{2'b01, 1, 1'b0, 1'b0, 1'b1, 2'b01, 64, 63};
    vecs[1] = '{2'b00, 1, 1'b0, 1'b0, 1'b1, 2'b00, 16, 15};
    vecs[2] = '{2'b01, 3, 1'b1, 1'b0, 1'b0, 2'b01, 192, 63};
    vecs[3] = '{2'b00, 2, 1'b1, 1'b1, 1'b0, 2'b00, 32, 15};
    vecs[4] = '{2'b10, 1, 1'b0, 1'b1, 1'b1, 2'b00, 16, 15};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    mode     = 2'b01;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_wr_rd", {31'd0, ram_wr_rd}, 32'd0);
    check("rst_wr_addr", {26'd0, ram_wr_addr}, 32'd0);
    check("rst_data_in", {16'd0, ram_data_in}, 32'd0);
    check("rst_rd_addr", {26'd0, ram_rd_addr}, 32'd0);
    check("rst_ram_mode", {30'd0, ram_mode}, 32'd1);
    check("rst_wr_state", {31'd0, dbg_wr_state}, 32'd0);
    check("rst_rd_state", {31'd0, dbg_rd_state}, 32'd0);
`ifdef IDCT_TPOSE_STATS_EN
    check("rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Table-driven block runs.
    for (int v = 0; v < 5; v++) begin
      mode     = vecs[v].mode;
      bp_en    = vecs[v].bp;
      max_addr = 0;
      pop0     = n_pop;
      tog0     = n_toggle;
      n        = vecs[v].mode[0] ? 8 : 4;
      for (int b = 0; b < vecs[v].nblk; b++) begin
        send_block(n, vecs[v].rnd);
        if (vecs[v].chk_lat) begin
          lat = 0;
          while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
          end
          check("first_out_latency", lat, 3);
        end
        if (b == 1 && vecs[v].nblk > 2) begin
          for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("in_ready_while_full", {31'd0, in_ready}, 32'd0);
          end
          @(posedge clk);
          #1;
        end
      end
      wait_drain();
      bp_en = 1'b0;
      check("vec_outputs", n_pop - pop0, vecs[v].exp_outs);
      check("vec_ram_mode", {30'd0, ram_mode}, {30'd0, vecs[v].exp_ram_mode});
      check("vec_wr_rd_toggles", n_toggle - tog0, vecs[v].nblk);
      check("vec_max_rd_addr", max_addr, vecs[v].exp_max_addr);
`ifdef IDCT_TPOSE_STATS_EN
      check("vec_blk_cnt", {16'd0, blk_cnt}, n_last_pop);
`endif
    end

    // Mode change with a full 8x8 block still in flight.
    mode = 2'b01;
    pop0 = n_pop;
    send_block(8, 1'b1);
    mode   = 2'b00;
    budget = 0;
    while (budget < 3000) begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
    end
    check("mode_chg_pops_at_ready", n_pop - pop0, 64);
    check("mode_chg_ram_mode", {30'd0, ram_mode}, 32'd0);
    @(posedge clk);
    #1;
    send_block(4, 1'b0);
    wait_drain();
    check("mode_chg_total_pops", n_pop - pop0, 80);

    // Reset in the middle of a drain.
    mode = 2'b01;
    pop0 = n_pop;
    send_block(8, 1'b0);
    budget = 0;
    while ((n_pop - pop0) < 20 && budget < 3000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    check("pre_reset_pops", n_pop - pop0, 20);
    check("pre_reset_wr_rd", {31'd0, ram_wr_rd}, 32'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_wr_rd", {31'd0, ram_wr_rd}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
`ifdef IDCT_TPOSE_STATS_EN
    check("mid_rst_blk_cnt", {16'd0, blk_cnt}, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst        = 1'b0;
    n_last_pop = 0;
    pop0       = n_pop;
    send_block(8, 1'b0);
    wait_drain();
    check("post_rst_outputs", n_pop - pop0, 64);
`ifdef IDCT_TPOSE_STATS_EN
    check("post_rst_blk_cnt", {16'd0, blk_cnt}, n_last_pop);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
